fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage for the 9-bit processor.
- Owns the program counter and drives the synchronous instruction ROM.
- Presents one registered machine-code word per cycle to the control decoder and register-file stage, with a valid flag.
- Handles start/done sequencing, downstream stall, taken-branch redirect and halt detection.

Parameters:
- PC_W, 10, program counter / ROM address width.
- INSTR_W, 9, machine-code word width.
- START_PC, 0, address fetched first after start.
- HALT_INSTR, 9'h1FF, encoding that terminates the program.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-low reset.
- start  input  1  level; begins execution from START_PC.
- stall  input  1  downstream hold request.
- branch_taken  input  1  redirect request for the current valid instr.
- branch_target  input  PC_W  redirect address.
- imem_addr  output  PC_W  ROM read address (combinational).
- imem_rdata  input  INSTR_W  ROM data, one cycle after its address.
- instr  output  INSTR_W  registered instruction to decoder.
- instr_pc  output  PC_W  address of instr.
- instr_valid  output  1  instr is live this cycle.
- done  output  1  program halted.
- instr_count  output  16  retired-instruction count (see Optional Feature).

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk; reset==0 wins over all other inputs, including mid-branch and mid-stall.
  - Values after reset: state=IDLE, fetch_pc=START_PC, inflight_valid=0, instr=0, instr_pc=0, instr_valid=0, done=0, instr_count=0.
- State IDLE:
  - imem_addr=START_PC.
  - start=1 -> RUN; inflight_pc<=START_PC, inflight_valid<=1, fetch_pc<=START_PC+1.
- State RUN: two-stage fetch (issue, capture); fixed 1-cycle ROM latency.
  - First instr_valid arrives 2 cycles after start is sampled.
- imem_addr mux, priority order:
  - stall=1 -> inflight_pc (re-read keeps imem_rdata stable).
  - else branch_taken=1 -> branch_target.
  - else fetch_pc.
- Normal cycle (stall=0, branch_taken=0):
  - instr<=imem_rdata, instr_pc<=inflight_pc, instr_valid<=inflight_valid.
  - inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1.
- Stall=1: every register holds, including instr_valid. branch_taken is ignored while stall=1.
- Branch (branch_taken=1, instr_valid=1, stall=0):
  - The in-flight word is discarded: instr_valid<=0.
  - inflight_pc<=branch_target, inflight_valid<=1, fetch_pc<=branch_target+1.
  - Target instruction is valid 2 cycles later (exactly one bubble).
  - branch_taken with instr_valid=0 is ignored.
- PC arithmetic: modulo 2^PC_W; 0x3FF+1 wraps to 0x000 silently. branch_target is used unchanged.
- Halt: instr_valid=1, instr==HALT_INSTR and stall=0 ->
  - next state HALT; done<=1, instr_valid<=0, inflight_valid<=0.
  - The halt word itself is consumed (it is valid for its one cycle).
  - Halt takes precedence over a simultaneous branch_taken.
- State HALT:
  - done held at 1; imem_addr=START_PC; no fetching.
  - start=0 -> IDLE with done<=0.
  - start held at 1 remains in HALT; a fresh rising level is needed to restart.
- start is ignored while in RUN.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined: instr_count increments by 1 on each cycle where instr_valid=1 and stall=0 (halt word included).
  - Saturates at 16'hFFFF.
  - Cleared by reset and on the IDLE->RUN transition.
  - Holds its value in HALT.
- Not defined: instr_count is tied to 16'h0000 and no counter logic is instantiated.

Test Plan:
- Straight-line run: ROM[0..3]=9'h001,9'h002,9'h003,9'h1FF; reset, start=1 -> instr_valid first high in cycle 2 after start, with instr_pc 0,1,2,3 on consecutive cycles; done=1 the cycle after instr_pc=3; instr_count=4 (with FETCH_COUNT_EN).
- Stall: assert stall for 3 cycles while instr_pc=1 -> instr=ROM[1] and instr_pc=1 held for all 3 cycles; instr_pc=2 appears the cycle after stall drops; no word lost or duplicated.
- Branch: branch_taken=1, branch_target=0x040 while instr_pc=2 -> next cycle instr_valid=0, then instr_pc=0x040 with instr=ROM[0x040]; address 3 is never presented valid.
- Branch during stall plus halt/branch collision: branch_taken=1 with stall=1 -> ignored, instr_pc unchanged; HALT_INSTR valid with branch_taken=1 -> done=1, no redirect.
- Wrap and reset: START_PC=0x3FE -> instr_pc sequence 0x3FE,0x3FF,0x000; reset=0 asserted mid-run -> all outputs 0 and state IDLE on the next edge.
- Restart: in HALT, drop start for 1 cycle then raise it -> done=0, execution restarts at START_PC; instr_count restarts from 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 9-bit processor: owns the PC, drives the synchronous ROM, presents one word per cycle.
// Optional retired-instruction counter enabled by defining FETCH_COUNT_EN; otherwise instr_count is tied to zero.
module fetch_unit #(
  parameter int                   PC_W       = 10,
  parameter int                   INSTR_W    = 9,
  parameter logic [PC_W-1:0]      START_PC   = '0,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               done,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t             state_reg, state_next;
  logic [PC_W-1:0]    fetch_pc_reg, fetch_pc_next;
  logic [PC_W-1:0]    inflight_pc_reg, inflight_pc_next;
  logic               inflight_valid_reg, inflight_valid_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [PC_W-1:0]    instr_pc_reg, instr_pc_next;
  logic               instr_valid_reg, instr_valid_next;
  logic               done_reg, done_next;

  logic accept;
  logic is_halt;
  logic redirect;

  // A word retires when it is valid and not held; the halt word wins over a branch.
  assign accept   = instr_valid_reg && !stall;
  assign is_halt  = accept && (instr_reg == HALT_INSTR);
  assign redirect = accept && branch_taken && !is_halt;

  always_comb begin
    state_next          = state_reg;
    fetch_pc_next       = fetch_pc_reg;
    inflight_pc_next    = inflight_pc_reg;
    inflight_valid_next = inflight_valid_reg;
    instr_next          = instr_reg;
    instr_pc_next       = instr_pc_reg;
    instr_valid_next    = instr_valid_reg;
    done_next           = done_reg;
    imem_addr           = START_PC;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next          = RUN;
          inflight_pc_next    = START_PC;
          inflight_valid_next = 1'b1;
          fetch_pc_next       = START_PC + 1'b1;
        end
      end

      RUN: begin
        // Re-reading the in-flight address during a stall keeps imem_rdata stable.
        if (stall) begin
          imem_addr = inflight_pc_reg;
        end else if (branch_taken && instr_valid_reg) begin
          imem_addr = branch_target;
        end else begin
          imem_addr = fetch_pc_reg;
        end

        if (!stall) begin
          if (is_halt) begin
            state_next          = HALT;
            done_next           = 1'b1;
            instr_valid_next    = 1'b0;
            inflight_valid_next = 1'b0;
          end else if (redirect) begin
            instr_valid_next    = 1'b0;
            inflight_pc_next    = branch_target;
            inflight_valid_next = 1'b1;
            fetch_pc_next       = branch_target + 1'b1;
          end else begin
            instr_next       = imem_rdata;
            instr_pc_next    = inflight_pc_reg;
            instr_valid_next = inflight_valid_reg;
            inflight_pc_next = fetch_pc_reg;
            fetch_pc_next    = fetch_pc_reg + 1'b1;
          end
        end
      end

      HALT: begin
        if (!start) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg          <= IDLE;
      fetch_pc_reg       <= START_PC;
      inflight_pc_reg    <= START_PC;
      inflight_valid_reg <= 1'b0;
      instr_reg          <= '0;
      instr_pc_reg       <= '0;
      instr_valid_reg    <= 1'b0;
      done_reg           <= 1'b0;
    end else begin
      state_reg          <= state_next;
      fetch_pc_reg       <= fetch_pc_next;
      inflight_pc_reg    <= inflight_pc_next;
      inflight_valid_reg <= inflight_valid_next;
      instr_reg          <= instr_next;
      instr_pc_reg       <= instr_pc_next;
      instr_valid_reg    <= instr_valid_next;
      done_reg           <= done_next;
    end
  end

  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign done        = done_reg;

`ifdef FETCH_COUNT_EN
  logic [15:0] count_reg, count_next;

  // Cleared when a run begins, saturating; holds through HALT because nothing is valid there.
  always_comb begin
    count_next = count_reg;
    if (state_reg == IDLE && start) begin
      count_next = '0;
    end else if (accept && count_reg != 16'hFFFF) begin
      count_next = count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign instr_count = count_reg;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan sequences with literal expectations, then randomized
// stimulus against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [9:0] START  = 10'h000;
  localparam logic [9:0] WSTART = 10'h3FE;
  localparam logic [8:0] HALT_W = 9'h1FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [9:0] branch_target = '0;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata = '0;
  logic [8:0] instr;
  logic [9:0] instr_pc;
  logic       instr_valid, done;
  logic [15:0] instr_count;

  logic        w_stall = 1'b0, w_branch = 1'b0;
  logic [9:0]  w_target = '0;
  logic [9:0]  w_imem_addr;
  logic [8:0]  w_imem_rdata = '0;
  logic [8:0]  w_instr;
  logic [9:0]  w_instr_pc;
  logic        w_instr_valid, w_done;
  logic [15:0] w_instr_count;

  logic [8:0] rom [1024];

  fetch_unit #(.PC_W(10), .INSTR_W(9), .START_PC(START), .HALT_INSTR(HALT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .done(done), .instr_count(instr_count)
  );

  // Second instance starting near the top of the address space to exercise PC wrap.
  fetch_unit #(.PC_W(10), .INSTR_W(9), .START_PC(WSTART), .HALT_INSTR(HALT_W)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .stall(w_stall),
    .branch_taken(w_branch), .branch_target(w_target),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
    .done(w_done), .instr_count(w_instr_count)
  );

  always @(posedge clk) imem_rdata <= rom[imem_addr];
  always @(posedge clk) w_imem_rdata <= {1'b0, w_imem_addr[7:0]};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=run 2=halted; cur word shown, and the address that will be shown next.
  int         m_mode = 0;
  bit         m_valid = 1'b0;
  logic [9:0] m_pc = '0;
  logic [8:0] m_instr = '0;
  logic [9:0] m_next = '0;
  bit         m_done = 1'b0;
  int         m_count = 0;

  function automatic logic [9:0] exp_addr();
    if (m_mode != 1) return START;
    if (stall) return m_next;
    if (branch_taken && m_valid) return branch_target;
    return m_next + 10'd1;
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_mode = 0; m_valid = 0; m_pc = '0; m_instr = '0; m_done = 0; m_count = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1; m_next = START; m_count = 0;
      end
    end else if (m_mode == 1) begin
      if (!stall) begin
        if (m_valid && m_count < 65535) m_count++;
        if (m_valid && m_instr == HALT_W) begin
          m_mode = 2; m_done = 1; m_valid = 0;
        end else if (m_valid && branch_taken) begin
          m_valid = 0; m_next = branch_target;
        end else begin
          m_valid = 1; m_pc = m_next; m_instr = rom[m_next]; m_next = m_next + 10'd1;
        end
      end
    end else begin
      if (!start) begin
        m_mode = 0; m_done = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("instr_valid", instr_valid, m_valid);
    chk("done", done, m_done);
`ifdef FETCH_COUNT_EN
    chk("instr_count", instr_count, m_count);
`else
    chk("instr_count", instr_count, 0);
`endif
    if (m_valid) begin
      chk("instr_pc", instr_pc, m_pc);
      chk("instr", instr, m_instr);
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit sl, input bit br, input logic [9:0] tgt);
    reset = rst; start = st; stall = sl; branch_taken = br; branch_target = tgt;
    #1;
    chk("imem_addr", imem_addr, exp_addr());
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic lit_count(input string name, input int exp);
`ifdef FETCH_COUNT_EN
    chk(name, instr_count, exp);
`else
    chk(name, instr_count, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = HALT_W;
    rom[10'h040] = 9'h055; rom[10'h041] = HALT_W;

    @(negedge clk);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    lit_count("rst_count", 0);

    // Straight-line run to halt; wrap instance runs alongside.
    cycle(1, 1, 0, 0, '0);
    chk("sl_c1_valid", instr_valid, 0);
    cycle(1, 1, 0, 0, '0);
    chk("sl_pc0", instr_pc, 10'h000); chk("sl_i0", instr, 9'h001); chk("sl_v0", instr_valid, 1);
    chk("wrap_pc0", w_instr_pc, 10'h3FE); chk("wrap_v0", w_instr_valid, 1);
    cycle(1, 1, 0, 0, '0);
    chk("sl_pc1", instr_pc, 10'h001); chk("wrap_pc1", w_instr_pc, 10'h3FF);
    cycle(1, 1, 0, 0, '0);
    chk("sl_pc2", instr_pc, 10'h002); chk("wrap_pc2", w_instr_pc, 10'h000);
    chk("wrap_i2", w_instr, 9'h000);
    cycle(1, 1, 0, 0, '0);
    chk("sl_pc3", instr_pc, 10'h003); chk("sl_i3", instr, 9'h1FF);
    cycle(1, 1, 0, 0, '0);
    chk("sl_done", done, 1); chk("sl_valid_after_halt", instr_valid, 0);
    lit_count("sl_count", 4);
    cycle(1, 1, 0, 0, '0);
    chk("halt_held", done, 1);

    // Restart, stall, branch during stall, branch, halt/branch collision.
    cycle(1, 0, 0, 0, '0);
    chk("rs_done_clr", done, 0);
    cycle(1, 1, 0, 0, '0);
    lit_count("rs_count_clr", 0);
    cycle(1, 1, 0, 0, '0);
    chk("rs_pc0", instr_pc, 10'h000);
    cycle(1, 1, 0, 0, '0);
    chk("rs_pc1", instr_pc, 10'h001);
    cycle(1, 1, 1, 0, '0);
    chk("st1_pc", instr_pc, 10'h001); chk("st1_i", instr, 9'h002);
    cycle(1, 1, 1, 0, '0);
    chk("st2_pc", instr_pc, 10'h001);
    cycle(1, 1, 1, 1, 10'h080);
    chk("st3_pc", instr_pc, 10'h001); chk("st3_v", instr_valid, 1);
    cycle(1, 1, 0, 0, '0);
    chk("st_rel_pc", instr_pc, 10'h002); chk("st_rel_i", instr, 9'h003);
    cycle(1, 1, 0, 1, 10'h040);
    chk("br_bubble", instr_valid, 0);
    cycle(1, 1, 0, 0, '0);
    chk("br_pc", instr_pc, 10'h040); chk("br_i", instr, 9'h055); chk("br_v", instr_valid, 1);
    cycle(1, 1, 0, 0, '0);
    chk("hb_pc", instr_pc, 10'h041);
    cycle(1, 1, 0, 1, 10'h100);
    chk("hb_done", done, 1); chk("hb_valid", instr_valid, 0);
    lit_count("hb_count", 5);

    // Reset mid-run with stall and branch asserted.
    cycle(1, 0, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    cycle(0, 1, 1, 1, 10'h100);
    chk("mr_valid", instr_valid, 0); chk("mr_pc", instr_pc, 0); chk("mr_instr", instr, 0);
    chk("mr_done", done, 0); lit_count("mr_count", 0);
    cycle(1, 0, 0, 0, '0);

    // Randomized phase with fresh ROM contents (DUT is idle, nothing valid).
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 39) == 0) ? HALT_W : 9'($urandom_range(0, 510));
    for (int n = 0; n < 4000; n++) begin
      logic [9:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 10'h3FE : 10'($urandom_range(0, 1023));
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
